// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared datapath definitions for the program counter slice.
//   DEFAULT_WIDTH : default address width in bits
//   PS_*          : PC source select encodings driven by the control unit
// -----------------------------------------------------------------------------
package pc_pkg;

  localparam int DEFAULT_WIDTH = 64;

  // PC source select encodings (control unit PS field)
  localparam logic [1:0] PS_HOLD = 2'b00;  // keep current PC
  localparam logic [1:0] PS_INC  = 2'b01;  // sequential PC + 4
  localparam logic [1:0] PS_REG  = 2'b10;  // absolute target from register (BR)
  localparam logic [1:0] PS_REL  = 2'b11;  // PC-relative branch (B/CBZ)

endpackage : pc_pkg

// File: rtl/pc_adder.sv
// -----------------------------------------------------------------------------
// pc_adder
// WIDTH-bit unsigned adder, result modulo 2^WIDTH (carry-out discarded).
// Ports:
//   a_i   : first operand
//   b_i   : second operand
//   sum_o : a_i + b_i, truncated to WIDTH bits
// -----------------------------------------------------------------------------
module pc_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule : pc_adder

// File: rtl/pc.sv
// -----------------------------------------------------------------------------
// pc
// Program counter for the ARMv8 datapath. Holds the address of the current
// instruction and, when load is high, updates it on the rising clock edge from
// one of four sources chosen by PS: hold, PC+4, register target X, or the
// PC-relative target PC + (X << 2).
// Ports:
//   clock  : sole clock, rising edge active
//   reset  : synchronous active-high clear of the PC
//   load   : update enable; PC holds when low regardless of PS
//   PS     : PC source select (see pc_pkg PS_* encodings)
//   X      : jump target (PS_REG) or signed word offset (PS_REL)
//   PC_out : current PC, driven straight from the register
// Internal nets PC4 and Adder_Out keep fixed names for hierarchical probing.
// -----------------------------------------------------------------------------
module pc
  import pc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [1:0]       PS,
  input  logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] PC_out
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] sel_s;
  logic [WIDTH-1:0] four_s;
  logic [WIDTH-1:0] offset_s;
  logic [WIDTH-1:0] PC4;
  logic [WIDTH-1:0] Adder_Out;

  assign four_s = {{(WIDTH-3){1'b0}}, 3'b100};

  // Word offset: dropping X's top two bits still gives the correct
  // two's-complement result once added modulo 2^WIDTH.
  assign offset_s = {X[WIDTH-3:0], 2'b00};

  pc_adder #(.WIDTH(WIDTH)) u_add_inc (
    .a_i   (pc_q),
    .b_i   (four_s),
    .sum_o (PC4)
  );

  pc_adder #(.WIDTH(WIDTH)) u_add_rel (
    .a_i   (pc_q),
    .b_i   (offset_s),
    .sum_o (Adder_Out)
  );

  // Source select mux followed by the load-enable mux.
  always_comb begin
    sel_s = pc_q;
    case (PS)
      PS_HOLD: sel_s = pc_q;
      PS_INC:  sel_s = PC4;
      PS_REG:  sel_s = X;
      PS_REL:  sel_s = Adder_Out;
      default: sel_s = pc_q;
    endcase

    if (load) begin
      pc_d = sel_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register with synchronous reset taking priority over load/PS.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= {WIDTH{1'b0}};
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_out = pc_q;

endmodule : pc

// File: tb/tb_pc.sv
// -----------------------------------------------------------------------------
// tb_pc
// Self-checking bench for pc: a directed vector table followed by random
// stimulus compared against a behavioural model of the PC update rules.
// -----------------------------------------------------------------------------
module tb_pc;

  localparam int W = 64;

  logic         clock;
  logic         reset;
  logic         load;
  logic [1:0]   PS;
  logic [W-1:0] X;
  logic [W-1:0] PC_out;

  int pass_cnt;
  int total_cnt;

  pc #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .PS     (PS),
    .X      (X),
    .PC_out (PC_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [1:0]   ps;
    logic [W-1:0] x;
    logic [W-1:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference rule for the next PC, written from the behavioural definition.
  function automatic logic [W-1:0] model_next(input logic rst, input logic ld,
                                               input logic [1:0] ps,
                                               input logic [W-1:0] x,
                                               input logic [W-1:0] cur);
    logic [W-1:0] r;
    if (rst) r = 64'd0;
    else if (!ld) r = cur;
    else if (ps == 2'd1) r = cur + 64'd4;
    else if (ps == 2'd2) r = x;
    else if (ps == 2'd3) r = cur + x * 64'd4;
    else r = cur;
    return r;
  endfunction

  // Drive one cycle; optionally check the combinational nets before the edge
  // and the registered PC after it.
  task automatic step(input logic rst, input logic ld, input logic [1:0] ps,
                      input logic [W-1:0] x, input logic known,
                      input logic [W-1:0] cur, input logic [W-1:0] exp);
    @(negedge clock);
    reset = rst; load = ld; PS = ps; X = x;
    #1;
    if (known) begin
      chk("PC4", dut.PC4, cur + 64'd4);
      chk("Adder_Out", dut.Adder_Out, cur + x * 64'd4);
    end
    @(posedge clock);
    #1;
    chk("PC_out", PC_out, exp);
  endtask

  initial begin
    logic [W-1:0] model_pc;
    logic         known;
    logic [W-1:0] xr;
    logic         rr;
    logic         lr;
    logic [1:0]   pr;

    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1; load = 1'b0; PS = 2'b00; X = 64'd0;

    // rst, ld, ps, x, expected PC after the edge
    vecs.push_back('{1'b1, 1'b0, 2'b00, 64'd0,  64'd0});
    vecs.push_back('{1'b1, 1'b1, 2'b01, 64'd0,  64'd0});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 64'd10, 64'd0});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 64'd0,  64'd4});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 64'd7,  64'd8});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 64'd0,  64'd12});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 64'd8,  64'd8});
    vecs.push_back('{1'b0, 1'b0, 2'b10, 64'd10, 64'd8});
    vecs.push_back('{1'b0, 1'b0, 2'b01, 64'd10, 64'd8});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 64'd10, 64'd10});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 64'd8,  64'd8});
    vecs.push_back('{1'b0, 1'b1, 2'b11, 64'd10, 64'd48});
    vecs.push_back('{1'b0, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'd40});
    vecs.push_back('{1'b0, 1'b1, 2'b00, 64'd99, 64'd40});
    vecs.push_back('{1'b0, 1'b0, 2'b11, 64'd5,  64'd40});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 64'd10, 64'd0});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 64'h13, 64'h13});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFC,
                     64'hFFFF_FFFF_FFFF_FFFC});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 64'd0,  64'd0});
    vecs.push_back('{1'b0, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_FFFF_FFFC});

    known = 1'b0;
    model_pc = 64'd0;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].ps, vecs[i].x, known, model_pc,
           vecs[i].exp_pc);
      model_pc = vecs[i].exp_pc;
      known = 1'b1;
    end

    // Hand sequence: Adder_Out reflects X immediately, independent of load.
    @(negedge clock);
    reset = 1'b0; load = 1'b0; PS = 2'b00; X = 64'd3;
    #1;
    chk("Adder_Out_noload", dut.Adder_Out, model_pc + 64'd12);
    @(posedge clock);
    #1;
    chk("PC_out_noload", PC_out, model_pc);

    // Random stimulus against the model.
    for (int n = 0; n < 300; n++) begin
      rr = ($urandom_range(15) == 0);
      lr = ($urandom_range(3) != 0);
      pr = 2'($urandom_range(3));
      xr = {$urandom, $urandom};
      if ($urandom_range(7) == 0) xr = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
      step(rr, lr, pr, xr, 1'b1, model_pc,
           model_next(rr, lr, pr, xr, model_pc));
      model_pc = model_next(rr, lr, pr, xr, model_pc);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_pc
